apb_req_arbiter: RTL

- Two-requester arbiter and APB4 completer driver for the single 1-bit-address APB register slave.
- Accepts simple valid/ready register requests from two internal clients and grants them round-robin.
- Sequences the granted request through the APB SETUP and ACCESS phases, then returns read data and error status to the winning client.
- Provides a bounded-wait timeout so a stuck PREADY cannot hang either client.

---
 rtl/apb_req_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Two-client round-robin arbiter driving a single APB4 completer.
// Sequences SETUP/ACCESS, returns rdata/err, aborts stuck transfers.
module apb_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_addr,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strb,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic            last_grant;
  logic            gnt_q;
  logic            grant;
  logic            accept;
  logic            timeout_hit;
  logic            done;
  logic [TO_W-1:0] to_cnt;
  logic [5:0]      wsel;
  logic [2:0]      ssel;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): grant = ~last_grant;
      (req_valid == 2'b10): grant = 1'b1;
      (req_valid == 2'b01): grant = 1'b0;
      default:              grant = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      req_ready = req_valid & (grant ? 2'b10 : 2'b01);
    end
  end

  assign accept = (state == IDLE) && (|req_valid);
  assign wsel   = {grant, 5'b00000};
  assign ssel   = {grant, 2'b00};

  // Abort on the last allowed wait cycle; PREADY still wins.
  assign timeout_hit = TO_EN && !PREADY &&
                       (to_cnt == TO_LAST);
  assign done = PREADY || timeout_hit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      to_cnt     <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (accept) begin
            gnt_q      <= grant;
            last_grant <= grant;
            PADDR      <= req_addr[grant];
            PWRITE     <= req_write[grant];
            PWDATA     <= req_write[grant] ?
                          req_wdata[wsel +: 32] : '0;
            PSTRB      <= req_write[grant] ?
                          req_strb[ssel +: 4] : '0;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            to_cnt    <= '0;
            rsp_valid <= gnt_q ? 2'b10 : 2'b01;
            rsp_rdata <= (PREADY && !PWRITE) ?
                         PRDATA : '0;
            rsp_err   <= PREADY ? PSLVERR : 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          to_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
